// File: rtl/cnn_mem_pkg.sv
// Shared constants and FSM encoding for the CNN feature-map scratchpad.
package cnn_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    // Same base the accelerator uses by default for its input feature map.
    localparam logic [31:0] CNN_FMAP_BASE  = 32'h1A10_0000;
    localparam int unsigned CNN_FMAP_WORDS = 256;

    // The wait counter is 4 bits wide; larger settings saturate at 15.
    function automatic logic [3:0] wait_init(input int unsigned cycles);
        return (cycles > 32'd15) ? 4'hF : cycles[3:0];
    endfunction

endpackage

// File: rtl/obi_pkg.sv
// OBI bus configuration and channel structs used by the scratchpad and its initiators.
package obi_pkg;

    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 4};

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [3:0]  aid;
        logic        a_optional;
    } obi_a_chan_t;

    typedef struct packed {
        logic        req;
        obi_a_chan_t a;
    } obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [3:0]  rid;
        logic        err;
        logic        r_optional;
    } obi_r_chan_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_t;

endpackage

// File: rtl/cnn_fmap_mem_array.sv
// Single-port, byte-enabled, flop-based word storage with registered read.
// Replace this module when moving to an SRAM macro; the port list matches a typical macro.
module cnn_fmap_mem_array
    import cnn_mem_pkg::*;
#(
    parameter int unsigned NumWords = CNN_FMAP_WORDS,
    parameter int unsigned AW       = $clog2(NumWords)
) (
    input  logic          clk_i,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [NumWords];

    // Byte-lane write and registered read of the addressed word (contents are never reset).
    always_ff @(posedge clk_i) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/cnn_fmap_mem.sv
// OBI subordinate scratchpad for CNN feature maps: wait-state FSM, clear sweep,
// address decode and one-cycle response register around cnn_fmap_mem_array.
// Optional build macro CNN_FMAP_MEM_ERR_EN: out-of-range addresses answer with err=1
// and perform no write; without it the word index wraps into the array.
module cnn_fmap_mem
    import cnn_mem_pkg::*;
#(
    parameter obi_pkg::obi_cfg_t ObiCfg     = obi_pkg::ObiDefaultConfig,
    parameter type               obi_req_t  = obi_pkg::obi_req_t,
    parameter type               obi_rsp_t  = obi_pkg::obi_rsp_t,
    parameter int unsigned       NumWords   = CNN_FMAP_WORDS,
    parameter logic [31:0]       BaseAddr   = CNN_FMAP_BASE,
    parameter int unsigned       WaitCycles = 0
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     testmode_i,
    input  obi_req_t obi_req_i,
    output obi_rsp_t obi_rsp_o,
    input  logic     clear_i,
    output logic     clear_busy_o
);

    localparam int unsigned AW  = $clog2(NumWords);
    localparam int unsigned IdW = ObiCfg.IdWidth;

    state_t          state_q, state_d;
    logic [3:0]      wait_cnt_q, wait_cnt_d;
    logic            pending_q, pending_d;
    logic [AW-1:0]   clr_idx_q, clr_idx_d;
    logic            gnt_raw, gnt, accept;
    logic [31:0]     offset;
    logic [AW-1:0]   idx;
    logic            in_range;
    logic            rvalid_q, rsp_we_q, rsp_err_q;
    logic [IdW-1:0]  rid_q;
    logic            arr_we;
    logic [3:0]      arr_be;
    logic [AW-1:0]   arr_addr;
    logic [31:0]     arr_wdata, arr_rdata;
    logic            unused_bits;

    assign offset = obi_req_i.a.addr - BaseAddr;
    assign idx    = offset[AW+1:2];

`ifdef CNN_FMAP_MEM_ERR_EN
    // Subtraction wraps for addresses below BaseAddr, so one high-bit test covers both sides.
    assign in_range = (offset[31:AW+2] == '0);
`else
    assign in_range = 1'b1;
`endif

    assign unused_bits = ^{testmode_i, offset[1:0], offset[31:AW+2], obi_req_i.a.a_optional};

    // gnt must read 0 while reset is held, independent of the request.
    assign gnt    = gnt_raw & rst_ni;
    assign accept = gnt & obi_req_i.req;

    // Next-state logic: grant timing, wait countdown, clear arbitration and sweep progress.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        clr_idx_d  = clr_idx_q;
        pending_d  = pending_q | (clear_i && (state_q != CLEAR));
        gnt_raw    = 1'b0;
        case (state_q)
            IDLE: begin
                if (WaitCycles == 0) begin
                    gnt_raw = obi_req_i.req;
                end
                if (pending_q && !(gnt_raw && obi_req_i.req)) begin
                    state_d   = CLEAR;
                    clr_idx_d = '0;
                end else if ((WaitCycles != 0) && obi_req_i.req) begin
                    state_d    = WAIT;
                    wait_cnt_d = wait_init(WaitCycles);
                end
            end
            WAIT: begin
                if (!obi_req_i.req) begin
                    // Initiator withdrew the request: abandon it without an access.
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == 4'd0) begin
                    gnt_raw = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            CLEAR: begin
                clr_idx_d = clr_idx_q + AW'(1);
                if (clr_idx_q == AW'(NumWords - 1)) begin
                    pending_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state; reset discards any wait count or sweep in progress.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            pending_q  <= 1'b0;
            clr_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            pending_q  <= pending_d;
            clr_idx_q  <= clr_idx_d;
        end
    end

    // Response register: one rvalid cycle per accepted request, carrying its ID and kind.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q  <= 1'b0;
            rsp_we_q  <= 1'b0;
            rsp_err_q <= 1'b0;
            rid_q     <= '0;
        end else begin
            rvalid_q <= accept;
            if (accept) begin
                rsp_we_q  <= obi_req_i.a.we;
                rsp_err_q <= !in_range;
                rid_q     <= obi_req_i.a.aid;
            end
        end
    end

    // The sweep owns the array port; otherwise the accepted request drives it.
    always_comb begin
        arr_we    = accept && obi_req_i.a.we && in_range;
        arr_be    = obi_req_i.a.be;
        arr_addr  = idx;
        arr_wdata = obi_req_i.a.wdata;
        if (state_q == CLEAR) begin
            arr_we    = 1'b1;
            arr_be    = 4'hF;
            arr_addr  = clr_idx_q;
            arr_wdata = '0;
        end
    end

    cnn_fmap_mem_array #(
        .NumWords (NumWords),
        .AW       (AW)
    ) u_array (
        .clk_i (clk_i),
        .we    (arr_we),
        .be    (arr_be),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    // Drive the response bus; rdata is zero unless a successful read is being answered.
    always_comb begin
        obi_rsp_o          = '0;
        obi_rsp_o.gnt      = gnt;
        obi_rsp_o.rvalid   = rvalid_q;
        obi_rsp_o.r.rdata  = (rvalid_q && !rsp_we_q && !rsp_err_q) ? arr_rdata : '0;
        obi_rsp_o.r.rid    = rid_q;
`ifdef CNN_FMAP_MEM_ERR_EN
        obi_rsp_o.r.err    = rsp_err_q;
`else
        obi_rsp_o.r.err    = 1'b0;
`endif
    end

    assign clear_busy_o = pending_q | (state_q == CLEAR);

endmodule

// File: tb/tb_cnn_fmap_mem.sv
// Directed bench for cnn_fmap_mem: a zero-wait instance and a three-wait instance,
// with a reference word model and a response scoreboard per instance.
module tb_cnn_fmap_mem;
    import obi_pkg::*;

    localparam logic [31:0] BASE = 32'h1A10_0000;
    localparam int          NW   = 256;

    typedef struct {
        logic [31:0] rdata;
        logic [3:0]  rid;
        logic        err;
        int          cyc;
    } exp_t;

    logic     clk = 1'b0;
    logic     rst_n = 1'b0;
    obi_req_t rq0, rq3;
    obi_rsp_t rs0, rs3;
    logic     clr0, clr3, busy0, busy3;

    int n_cmp = 0;
    int n_err = 0;
    int cyc_cnt = 0;

    exp_t        q0[$];
    exp_t        q3[$];
    logic [31:0] mdl [2][NW];

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    cnn_fmap_mem #(.NumWords(NW), .BaseAddr(BASE), .WaitCycles(0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .testmode_i(1'b0),
        .obi_req_i(rq0), .obi_rsp_o(rs0), .clear_i(clr0), .clear_busy_o(busy0)
    );

    cnn_fmap_mem #(.NumWords(NW), .BaseAddr(BASE), .WaitCycles(3)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n), .testmode_i(1'b0),
        .obi_req_i(rq3), .obi_rsp_o(rs3), .clear_i(clr3), .clear_busy_o(busy3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic obi_req_t mkreq(input logic [31:0] addr, input logic we, input logic [3:0] be,
                                       input logic [31:0] wd, input logic [3:0] aid);
        obi_req_t r;
        r = '0;
        r.req     = 1'b1;
        r.a.addr  = addr;
        r.a.we    = we;
        r.a.be    = be;
        r.a.wdata = wd;
        r.a.aid   = aid;
        return r;
    endfunction

    // Pop and compare a response, or flag a response that should have arrived.
    task automatic check_rsp(input int d, input obi_rsp_t rs);
        exp_t e;
        int   n;
        n = (d == 0) ? q0.size() : q3.size();
        if (!rs.rvalid) begin
            if (n > 0) begin
                if (d == 0) e = q0[0]; else e = q3[0];
                if (e.cyc < cyc_cnt) begin
                    chk($sformatf("rsp_missing_dut%0d", d), 32'(rs.rvalid), 32'd1);
                    if (d == 0) void'(q0.pop_front()); else void'(q3.pop_front());
                end
            end
            return;
        end
        if (n == 0) begin
            chk($sformatf("rsp_unexpected_dut%0d", d), 32'(rs.rvalid), 32'd0);
            return;
        end
        if (d == 0) e = q0.pop_front(); else e = q3.pop_front();
        chk($sformatf("rdata_dut%0d", d), rs.r.rdata, e.rdata);
        chk($sformatf("rid_dut%0d", d), 32'(rs.r.rid), 32'(e.rid));
        chk($sformatf("err_dut%0d", d), 32'(rs.r.err), 32'(e.err));
        chk($sformatf("latency_dut%0d", d), cyc_cnt - e.cyc, 32'd1);
    endtask

    // On an accepted request, update the model and queue the expected response.
    task automatic note_req(input int d, input obi_req_t rq, input obi_rsp_t rs);
        exp_t        e;
        logic [31:0] off;
        logic [7:0]  ix;
        logic        inr;
        if (!(rq.req && rs.gnt)) return;
        off = rq.a.addr - BASE;
        ix  = off[9:2];
`ifdef CNN_FMAP_MEM_ERR_EN
        inr = (off < 32'd1024);
`else
        inr = 1'b1;
`endif
        e.rid = rq.a.aid;
        e.err = !inr;
        e.cyc = cyc_cnt;
        if (rq.a.we) begin
            e.rdata = '0;
            if (inr) begin
                for (int b = 0; b < 4; b++) begin
                    if (rq.a.be[b]) mdl[d][ix][8*b +: 8] = rq.a.wdata[8*b +: 8];
                end
            end
        end else begin
            e.rdata = inr ? mdl[d][ix] : 32'd0;
        end
        if (d == 0) q0.push_back(e); else q3.push_back(e);
    endtask

    always @(negedge clk) begin
        check_rsp(0, rs0);
        check_rsp(1, rs3);
        note_req(0, rq0, rs0);
        note_req(1, rq3, rs3);
    end

    task automatic wait_gnt(input int d, output int waited);
        logic g;
        bit   done;
        waited = 0;
        done   = 1'b0;
        while (!done) begin
            @(negedge clk);
            g = (d == 0) ? rs0.gnt : rs3.gnt;
            if (g) begin
                done = 1'b1;
            end else begin
                waited++;
                if (waited >= 64) begin
                    chk($sformatf("gnt_timeout_dut%0d", d), 32'(g), 32'd1);
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic issue(input int d, input logic [31:0] addr, input logic we, input logic [3:0] be,
                         input logic [31:0] wd, input logic [3:0] aid, output int waited);
        if (d == 0) rq0 = mkreq(addr, we, be, wd, aid);
        else        rq3 = mkreq(addr, we, be, wd, aid);
        wait_gnt(d, waited);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int d);
        if (d == 0) rq0.req = 1'b0; else rq3.req = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int w, c0, nb;
        bit gbad, done;
        clr0 = 1'b0;
        clr3 = 1'b0;
        rq0  = mkreq(BASE, 1'b0, 4'hF, 32'd0, 4'd0);
        rq3  = mkreq(BASE, 1'b0, 4'hF, 32'd0, 4'd0);

        // Reset state, with requests held high to show gnt is forced low.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt0", 32'(rs0.gnt), 32'd0);
        chk("rst_gnt3", 32'(rs3.gnt), 32'd0);
        chk("rst_rvalid0", 32'(rs0.rvalid), 32'd0);
        chk("rst_rvalid3", 32'(rs3.rvalid), 32'd0);
        chk("rst_busy0", 32'(busy0), 32'd0);
        chk("rst_busy3", 32'(busy3), 32'd0);
        chk("rst_rdata0", rs0.r.rdata, 32'd0);
        chk("rst_rid0", 32'(rs0.r.rid), 32'd0);
        chk("rst_err0", 32'(rs0.r.err), 32'd0);
        rq0.req = 1'b0;
        rq3.req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Zero-wait instance: write/read, byte enables, out-of-range, throughput.
        issue(0, BASE + 32'h8, 1'b1, 4'hF, 32'hA5A5_1234, 4'd1, w);
        chk("w0_wait", w, 32'd0);
        issue(0, BASE + 32'h8, 1'b0, 4'hF, 32'd0, 4'd2, w);
        issue(0, BASE + 32'h8, 1'b1, 4'b0101, 32'hFFFF_FFFF, 4'd3, w);
        issue(0, BASE + 32'h8, 1'b0, 4'hF, 32'd0, 4'd4, w);
        issue(0, BASE + 32'h0, 1'b1, 4'hF, 32'h0BAD_F00D, 4'd5, w);
        issue(0, BASE + 32'h4, 1'b1, 4'hF, 32'h0000_0101, 4'd6, w);
        issue(0, BASE + 32'h400, 1'b0, 4'hF, 32'd0, 4'd7, w);
        issue(0, BASE + 32'h404, 1'b1, 4'hF, 32'h1111_2222, 4'd8, w);
        issue(0, BASE + 32'h4, 1'b0, 4'hF, 32'd0, 4'd9, w);
        issue(0, BASE + 32'hB, 1'b0, 4'hF, 32'd0, 4'd10, w);
        c0 = cyc_cnt;
        issue(0, BASE + 32'h0, 1'b0, 4'hF, 32'd0, 4'd11, w);
        issue(0, BASE + 32'h4, 1'b0, 4'hF, 32'd0, 4'd12, w);
        issue(0, BASE + 32'h8, 1'b0, 4'hF, 32'd0, 4'd13, w);
        issue(0, BASE + 32'h0, 1'b0, 4'hF, 32'd0, 4'd14, w);
        chk("w0_throughput", cyc_cnt - c0, 32'd4);
        idle(0);

        // Three-wait instance: grant delay and back-to-back spacing.
        issue(1, BASE + 32'h8, 1'b1, 4'hF, 32'h2222_0002, 4'd1, w);
        chk("w3_first_wait", w, 32'd4);
        c0 = cyc_cnt;
        issue(1, BASE + 32'h14, 1'b1, 4'hF, 32'h5555_0005, 4'd2, w);
        chk("w3_b2b_wait", w, 32'd4);
        chk("w3_spacing", cyc_cnt - c0, 32'd5);
        issue(1, BASE + 32'h8, 1'b0, 4'hF, 32'd0, 4'd3, w);
        idle(1);

        // Clear pulsed while a read waits: read finishes, then the sweep blocks grants.
        rq3 = mkreq(BASE + 32'h8, 1'b0, 4'hF, 32'd0, 4'd4);
        @(posedge clk); #1;
        clr3 = 1'b1;
        @(posedge clk); #1;
        clr3 = 1'b0;
        wait_gnt(1, w);
        chk("clr_pending_busy", 32'(busy3), 32'd1);
        @(posedge clk); #1;
        rq3 = mkreq(BASE + 32'h14, 1'b0, 4'hF, 32'd0, 4'd5);
        nb   = 0;
        gbad = 1'b0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (busy3) begin
                nb++;
                if (rs3.gnt) gbad = 1'b1;
                if (nb > 600) done = 1'b1;
            end else begin
                done = 1'b1;
            end
        end
        chk("clr_busy_len", nb, 32'(NW + 1));
        chk("clr_gnt_during", 32'(gbad), 32'd0);
        for (int i = 0; i < NW; i++) mdl[1][i] = 32'd0;
        wait_gnt(1, w);
        @(posedge clk); #1;
        issue(1, BASE + 32'h8, 1'b0, 4'hF, 32'd0, 4'd6, w);
        idle(1);

        // Reset in the middle of a sweep, with a zero-wait response in flight.
        issue(1, BASE + 32'hC, 1'b1, 4'hF, 32'h3333_0003, 4'd7, w);
        issue(1, BASE + 32'd800, 1'b1, 4'hF, 32'hC8C8_00C8, 4'd8, w);
        idle(1);
        clr3 = 1'b1;
        @(posedge clk); #1;
        clr3 = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        issue(0, BASE + 32'h8, 1'b0, 4'hF, 32'd0, 4'd15, w);
        rst_n = 1'b0;
        q0.delete();
        #1;
        chk("rst2_rvalid0", 32'(rs0.rvalid), 32'd0);
        chk("rst2_rid0", 32'(rs0.r.rid), 32'd0);
        chk("rst2_gnt0", 32'(rs0.gnt), 32'd0);
        chk("rst2_busy3", 32'(busy3), 32'd0);
        chk("rst2_rvalid3", 32'(rs3.rvalid), 32'd0);
        rq0.req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        mdl[1][3] = 32'd0;
        issue(1, BASE + 32'd800, 1'b0, 4'hF, 32'd0, 4'd9, w);
        chk("rst2_wait", w, 32'd4);
        issue(1, BASE + 32'hC, 1'b0, 4'hF, 32'd0, 4'd10, w);
        idle(1);
        issue(0, BASE + 32'h8, 1'b0, 4'hF, 32'd0, 4'd11, w);
        idle(0);

        repeat (3) @(posedge clk);
        #1;
        chk("drain_q0", q0.size(), 32'd0);
        chk("drain_q3", q3.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
